// File: rtl/sequenciador_oled_if.sv
// Signal bundle between the image controller, the OLED frame sequencer and the serial driver.
interface sequenciador_oled_if;
    logic [8191:0] imagem;
    logic          iniciar;
    logic [7:0]    byte_out;
    logic          dc;
    logic          valid;
    logic          ready;
    logic          ocupado;
    logic          quadro_fim;

    modport master (
        input  imagem,
        input  iniciar,
        input  ready,
        output byte_out,
        output dc,
        output valid,
        output ocupado,
        output quadro_fim
    );

    modport slave (
        output imagem,
        output iniciar,
        output ready,
        input  byte_out,
        input  dc,
        input  valid,
        input  ocupado,
        input  quadro_fim
    );
endinterface

// File: rtl/sequenciador_oled.sv
// OLED frame sequencer: 6 addressing commands then 1024 shadowed pixel bytes over valid/ready.
// Optional periodic refresh enabled by defining SEQUENCIADOR_OLED_AUTO_REFRESH_EN.
module sequenciador_oled #(
    parameter int unsigned REFRESH_CICLOS = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    sequenciador_oled_if.master  bus
);

    typedef enum logic [1:0] {OCIOSO, CMD, DADOS, FIM} estado_t;

    estado_t       estado_q, estado_d;
    logic [10:0]   indice_q, indice_d;
    logic          pendente_q, pendente_d;
    logic [8191:0] sombra_q;
    logic          captura;
    logic          pedido;
    logic          auto_req;

    logic [7:0]    byte_out;
    logic          dc;
    logic          valid;
    logic          ocupado;
    logic          quadro_fim;

    function automatic logic [7:0] comando(input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = 8'h21;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'h7F;
            3'd3:    b = 8'h22;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifdef SEQUENCIADOR_OLED_AUTO_REFRESH_EN
    localparam int unsigned CW = (REFRESH_CICLOS > 1) ? $clog2(REFRESH_CICLOS) : 1;
    localparam logic [CW-1:0] CONT_MAX = CW'(REFRESH_CICLOS - 1);

    logic [CW-1:0] cont_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q <= '0;
        end else if (cont_q == CONT_MAX) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_q + 1'b1;
        end
    end

    assign auto_req = (cont_q == CONT_MAX);
`else
    assign auto_req = 1'b0;
`endif

    // Automatic and external requests merge into one so coincident ones count once.
    assign pedido = bus.iniciar | auto_req;

    always_comb begin
        estado_d   = estado_q;
        indice_d   = indice_q;
        pendente_d = pendente_q;
        captura    = 1'b0;
        byte_out   = 8'h00;
        dc         = 1'b0;
        valid      = 1'b0;
        ocupado    = 1'b1;
        quadro_fim = 1'b0;

        if (estado_q != OCIOSO && pedido) begin
            pendente_d = 1'b1;
        end

        case (estado_q)
            OCIOSO: begin
                ocupado = 1'b0;
                if (pedido || pendente_q) begin
                    captura    = 1'b1;
                    pendente_d = 1'b0;
                    indice_d   = '0;
                    estado_d   = CMD;
                end
            end
            CMD: begin
                valid    = 1'b1;
                byte_out = comando(indice_q[2:0]);
                if (bus.ready) begin
                    if (indice_q == 11'd5) begin
                        indice_d = '0;
                        estado_d = DADOS;
                    end else begin
                        indice_d = indice_q + 11'd1;
                    end
                end
            end
            DADOS: begin
                valid    = 1'b1;
                dc       = 1'b1;
                byte_out = sombra_q[{indice_q[9:0], 3'b000} +: 8];
                if (bus.ready) begin
                    // Index parks at 1023; it is cleared only by the next capture.
                    if (indice_q == 11'd1023) begin
                        estado_d = FIM;
                    end else begin
                        indice_d = indice_q + 11'd1;
                    end
                end
            end
            FIM: begin
                quadro_fim = 1'b1;
                estado_d   = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            indice_q   <= '0;
            pendente_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            indice_q   <= indice_d;
            pendente_q <= pendente_d;
        end
    end

    // Shadow copy carries no reset; it is always written before being read.
    always_ff @(posedge clk) begin
        if (captura) begin
            sombra_q <= bus.imagem;
        end
    end

    assign bus.byte_out   = byte_out;
    assign bus.dc         = dc;
    assign bus.valid      = valid;
    assign bus.ocupado    = ocupado;
    assign bus.quadro_fim = quadro_fim;

endmodule

// File: tb/tb_sequenciador_oled.sv
// Directed bench for sequenciador_oled: framing, back-pressure, shadowing, pending and reset.
module tb_sequenciador_oled;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   first_pos;
    logic [7:0] first_got;
    logic [7:0] cmd_tab [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    sequenciador_oled_if bus ();

    sequenciador_oled #(
        .REFRESH_CICLOS(2000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pattern();
        for (int k = 0; k < 1024; k++) begin
            bus.imagem[k*8 +: 8] = 8'(k);
        end
    endtask

    task automatic start_frame();
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
    endtask

    // Consumes one frame from its first valid cycle until quadro_fim.
    task automatic recv_frame(input bit toggle, input bit pulsos, output int pos,
                              output int nval, output int fim_cyc, output int bad);
        logic [7:0] exp_b;
        logic       exp_dc;
        pos       = 0;
        nval      = 0;
        fim_cyc   = -1;
        bad       = 0;
        first_pos = -1;
        first_got = 8'h00;
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            if (pulsos) bus.iniciar = (cyc == 100 || cyc == 200 || cyc == 300);
            if (bus.quadro_fim === 1'b1) begin
                fim_cyc = cyc;
                if (bus.valid !== 1'b0) bad++;
                break;
            end
            if (bus.valid === 1'b1) begin
                nval++;
                if (pos < 6) begin
                    exp_b  = cmd_tab[pos];
                    exp_dc = 1'b0;
                end else begin
                    exp_b  = 8'(pos - 6);
                    exp_dc = 1'b1;
                end
                if (pos >= 1030 || bus.byte_out !== exp_b || bus.dc !== exp_dc ||
                    bus.ocupado !== 1'b1) begin
                    if (first_pos < 0) begin
                        first_pos = pos;
                        first_got = bus.byte_out;
                    end
                    bad++;
                end
                bus.ready = toggle ? cyc[0] : 1'b1;
                if (bus.ready) pos++;
            end else begin
                if (first_pos < 0) first_pos = pos;
                bad++;
            end
            step();
        end
        bus.iniciar = 1'b0;
        bus.ready   = 1'b1;
    endtask

    task automatic check_first_byte(input string name);
        checks++;
        if ({bus.valid, bus.dc, bus.ocupado, bus.byte_out} !== {1'b1, 1'b0, 1'b1, 8'h21}) begin
            errors++;
            $display("FAIL %s: valid=%b dc=%b ocupado=%b byte=%h, required 1 0 1 21", name,
                     bus.valid, bus.dc, bus.ocupado, bus.byte_out);
        end
    endtask

    task automatic check_frame(input string name, input int pos, input int fim_cyc,
                               input int exp_fim, input int bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s bytes: %0d bad cycles, first at pos %0d got %h, required 0",
                     name, bad, first_pos, first_got);
        end
        checks++;
        if (fim_cyc !== exp_fim) begin
            errors++;
            $display("FAIL %s quadro_fim cycle: got %0d, required %0d", name, fim_cyc, exp_fim);
        end
        checks++;
        if (pos !== 1030) begin
            errors++;
            $display("FAIL %s accepted count: got %0d, required 1030", name, pos);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({bus.valid, bus.ocupado, bus.quadro_fim, bus.dc, bus.byte_out} !== 12'h000) begin
            errors++;
            $display("FAIL %s: valid=%b ocupado=%b quadro_fim=%b dc=%b byte=%h, required all 0",
                     name, bus.valid, bus.ocupado, bus.quadro_fim, bus.dc, bus.byte_out);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.iniciar = 1'b1;
        bus.ready   = 1'b1;
        step();
        step();
        check_idle("reset with iniciar");
        rst         = 1'b0;
        bus.iniciar = 1'b0;
        repeat (3) step();
        check_idle("idle after reset, ready pulse ignored");
    endtask

    task automatic test_frame();
        int pos, nval, fim_cyc, bad;
        start_frame();
        check_first_byte("frame first byte");
        recv_frame(1'b0, 1'b0, pos, nval, fim_cyc, bad);
        check_frame("frame", pos, fim_cyc, 1031, bad);
        checks++;
        if (nval !== 1030) begin
            errors++;
            $display("FAIL frame valid cycles: got %0d, required 1030", nval);
        end
        step();
        check_idle("frame return to idle");
    endtask

    task automatic test_backpressure();
        int pos, nval, fim_cyc, bad;
        start_frame();
        recv_frame(1'b1, 1'b0, pos, nval, fim_cyc, bad);
        check_frame("backpressure", pos, fim_cyc, 2060, bad);
        checks++;
        if (nval !== 2059) begin
            errors++;
            $display("FAIL backpressure valid cycles: got %0d, required 2059", nval);
        end
        step();
    endtask

    task automatic test_shadow();
        int pos, nval, fim_cyc, bad;
        start_frame();
        for (int k = 0; k < 1024; k++) bus.imagem[k*8 +: 8] = 8'hAA;
        recv_frame(1'b0, 1'b0, pos, nval, fim_cyc, bad);
        check_frame("shadow", pos, fim_cyc, 1031, bad);
        load_pattern();
        step();
    endtask

    task automatic test_pending();
        int pos, nval, fim_cyc, bad;
        bit seen;
        start_frame();
        recv_frame(1'b0, 1'b1, pos, nval, fim_cyc, bad);
        check_frame("pending first", pos, fim_cyc, 1031, bad);
        step();
        check_idle("pending capture cycle");
        step();
        check_first_byte("pending second frame start");
        recv_frame(1'b0, 1'b0, pos, nval, fim_cyc, bad);
        check_frame("pending second", pos, fim_cyc, 1031, bad);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.valid !== 1'b0 || bus.ocupado !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL pending no third frame: activity=%b, required 0", seen);
        end
    endtask

    task automatic test_fim_request();
        int pos, nval, fim_cyc, bad;
        start_frame();
        recv_frame(1'b0, 1'b0, pos, nval, fim_cyc, bad);
        bus.iniciar = 1'b1;
        step();
        bus.iniciar = 1'b0;
        check_idle("fim request capture cycle");
        step();
        check_first_byte("fim request frame start");
        recv_frame(1'b0, 1'b0, pos, nval, fim_cyc, bad);
        check_frame("fim request", pos, fim_cyc, 1031, bad);
        step();
    endtask

    task automatic test_reset_midframe();
        int pos, nval, fim_cyc, bad;
        bit seen;
        start_frame();
        repeat (506) step();
        checks++;
        if ({bus.valid, bus.dc, bus.byte_out} !== {1'b1, 1'b1, 8'hF4}) begin
            errors++;
            $display("FAIL midframe byte 500: valid=%b dc=%b byte=%h, required 1 1 f4",
                     bus.valid, bus.dc, bus.byte_out);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midframe reset");
        seen = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (bus.valid !== 1'b0 || bus.quadro_fim !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midframe aborted: activity=%b, required 0", seen);
        end
        start_frame();
        check_first_byte("restart after reset");
        recv_frame(1'b0, 1'b0, pos, nval, fim_cyc, bad);
        check_frame("restart", pos, fim_cyc, 1031, bad);
        step();
    endtask

`ifdef SEQUENCIADOR_OLED_AUTO_REFRESH_EN
    task automatic test_auto();
        int t [3];
        int n;
        n = 0;
        for (int cyc = 0; cyc < 8000 && n < 3; cyc++) begin
            if (bus.quadro_fim === 1'b1) begin
                t[n] = cyc;
                n++;
            end
            step();
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL auto pulses seen: got %0d, required 3", n);
        end else begin
            checks++;
            if (t[1] - t[0] !== 2000) begin
                errors++;
                $display("FAIL auto spacing 1: got %0d, required 2000", t[1] - t[0]);
            end
            checks++;
            if (t[2] - t[1] !== 2000) begin
                errors++;
                $display("FAIL auto spacing 2: got %0d, required 2000", t[2] - t[1]);
            end
        end
    endtask
`endif

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        bus.iniciar = 1'b0;
        bus.ready   = 1'b0;
        bus.imagem  = '0;
        load_pattern();
        test_reset();
`ifdef SEQUENCIADOR_OLED_AUTO_REFRESH_EN
        test_auto();
`else
        test_frame();
        test_backpressure();
        test_shadow();
        test_pending();
        test_fim_request();
        test_reset_midframe();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequenciador_oled.md
SEQUENCIADOR_OLED -- requirements
Module: sequenciador_oled

Interface
REQ-001 Parameter: REFRESH_CICLOS, 50000, clk cycles between automatic frame starts (used only with AUTO_REFRESH_EN).
REQ-002 Port: clk  in  1  single system clock; all logic on rising edge.
REQ-003 Port: rst  in  1  reset; synchronous, active-high.
REQ-004 Port: imagem  in  8192  frame from image controller; byte k = imagem[k*8 +: 8], k = 0..1023.
REQ-005 Port: iniciar  in  1  frame transfer request; sampled every cycle.
REQ-006 Port: byte_out  out  8  byte offered to the OLED serial driver.
REQ-007 Port: dc  out  1  0 = command byte, 1 = pixel data byte.
REQ-008 Port: valid  out  1  byte_out/dc are valid.
REQ-009 Port: ready  in  1  driver accepts the byte this cycle.
REQ-010 Port: ocupado  out  1  frame transfer in progress.
REQ-011 Port: quadro_fim  out  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-012 The FSM SHALL have states OCIOSO, CMD, DADOS and FIM.
REQ-013 In OCIOSO, iniciar=1 (or a pending request) SHALL latch all 8192 bits of imagem into a shadow register and move to CMD with valid=1 on the next cycle.
REQ-014 CMD SHALL send 6 bytes with dc=0, in order: 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07.
REQ-015 DADOS SHALL send shadow bytes k = 0..1023 in ascending order with dc=1; k is held in an 11-bit index.
REQ-016 A transfer SHALL occur only on a cycle with valid=1 and ready=1.
REQ-017 While valid=1 and ready=0, byte_out and dc SHALL be held stable.
REQ-018 After a transfer, the next byte SHALL be presented on the following cycle, with valid still 1.
REQ-019 After a transfer, valid SHALL never drop inside a frame.
REQ-020 With ready tied to 1, one frame SHALL take exactly 1030 consecutive valid cycles.
REQ-021 Acceptance of byte 1023 SHALL move the FSM to FIM, where valid=0 and quadro_fim=1 for exactly one cycle.
REQ-022 From FIM the FSM SHALL return to OCIOSO.
REQ-023 ocupado SHALL be 1 in CMD, DADOS and FIM, and 0 in OCIOSO.
REQ-024 Changes on imagem during a transfer SHALL NOT affect the bytes sent.
REQ-025 iniciar=1 while ocupado=1 SHALL set a single pending flag; further requests SHALL NOT accumulate.
REQ-026 A set pending flag SHALL start a new frame in the cycle after FIM.
REQ-027 The pending flag SHALL clear when the new frame's capture occurs.
REQ-028 iniciar asserted in the FIM cycle SHALL count as pending.
REQ-029 The index SHALL NOT wrap past 1023.
REQ-030 A ready pulse while valid=0 SHALL have no effect.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL drive, from the next cycle: state=OCIOSO, byte_out=0x00, dc=0, valid=0, ocupado=0, quadro_fim=0, index=0, pending=0, refresh counter=0.
REQ-032 Reset mid-frame SHALL abort the frame with no quadro_fim pulse.
REQ-033 Reset SHALL take priority over iniciar and ready in the same cycle.
REQ-034 The shadow register SHALL need no reset value.

Configuration
REQ-035 The macro SEQUENCIADOR_OLED_AUTO_REFRESH_EN SHALL control automatic refresh.
REQ-036 When the macro is defined, a counter SHALL count 0..REFRESH_CICLOS-1 and wrap.
REQ-037 With the macro defined, each wrap SHALL act exactly as one iniciar pulse, either starting a frame or setting pending.
REQ-038 With the macro defined, an automatic request coinciding with iniciar SHALL count as a single request.
REQ-039 When the macro is undefined, the counter logic SHALL be absent and frames SHALL start only from iniciar.

Verification
REQ-040 Bench: reset, then imagem byte k = k[7:0], one-cycle iniciar, ready=1 -> 6 command bytes 21 00 7F 22 00 07 with dc=0, then 00..FF repeated 4 times with dc=1; quadro_fim exactly 1031 cycles after the iniciar edge.
REQ-041 Bench: ready toggling 1-0-1-0 during DADOS -> byte stable while ready=0, no byte lost or duplicated, final byte 0xFF at k=1023.
REQ-042 Bench: after capture, overwrite imagem with all 0xAA -> transmitted data still equals the original pattern.
REQ-043 Bench: iniciar pulsed 3 times during a frame -> exactly one extra frame, starting the cycle after the quadro_fim pulse.
REQ-044 Bench: rst=1 at data byte k=500 -> valid=0 and ocupado=0 next cycle, no quadro_fim; a fresh iniciar restarts with 0x21.
REQ-045 Bench: SEQUENCIADOR_OLED_AUTO_REFRESH_EN defined, REFRESH_CICLOS=2000, ready=1, no iniciar -> quadro_fim pulses spaced exactly 2000 cycles apart.
